// File: rtl/bpred_bht.sv
// bpred_bht: multi-lane branch-direction predictor.
// A table of saturating counters indexed bimodally (PC) or gshare (PC ^ history),
// with zero-latency lookups, in-order multi-lane updates, a non-speculative
// global history register and a saturating misprediction counter.
module bpred_bht #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int LANES    = 2,
  parameter int GHR_BITS = 6,
  parameter int MODE     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES*32-1:0]          lk_pc,
  output logic [LANES-1:0]             predict_taken,
  output logic [GHR_BITS-1:0]          ghr,
  input  logic [LANES-1:0]             upd_valid,
  input  logic [LANES*32-1:0]          upd_pc,
  input  logic [LANES*GHR_BITS-1:0]    upd_ghr,
  input  logic [LANES-1:0]             upd_taken,
  input  logic [LANES-1:0]             upd_mispredict,
  output logic [31:0]                  mispredict_cnt
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         misp_q, misp_d;
  logic [32:0]         misp_sum;
  logic [2:0]          pop;
  logic [IDX-1:0]      lk_idx;
  logic [IDX-1:0]      up_idx;

  // PC bits outside the index field (and history in bimodal mode) are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{lk_pc, upd_pc, upd_ghr};

  function automatic logic [IDX-1:0] bht_idx(input logic [31:0] pc,
                                             input logic [GHR_BITS-1:0] h);
    logic [IDX-1:0] hx;
    hx = '0;
    hx[GHR_BITS-1:0] = h;
    if (MODE == 1) return pc[IDX+1:2] ^ hx;
    return pc[IDX+1:2];
  endfunction

  assign ghr            = ghr_q;
  assign mispredict_cnt = misp_q;

  // Lookup: counter MSB from registered state, forced low while in reset.
  always_comb begin
    predict_taken = '0;
    lk_idx        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lk_idx           = bht_idx(lk_pc[32*i +: 32], ghr_q);
      predict_taken[i] = ~rst & ctr_q[lk_idx][CTR_BITS-1];
    end
  end

  // Next state: lanes applied in order, each step saturating on the running value.
  always_comb begin
    ctr_d  = ctr_q;
    ghr_d  = ghr_q;
    pop    = '0;
    up_idx = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (upd_valid[i]) begin
        up_idx = bht_idx(upd_pc[32*i +: 32], upd_ghr[GHR_BITS*i +: GHR_BITS]);
        if (upd_taken[i]) begin
          if (ctr_d[up_idx] != '1) ctr_d[up_idx] = ctr_d[up_idx] + CTR_BITS'(1);
        end else begin
          if (ctr_d[up_idx] != '0) ctr_d[up_idx] = ctr_d[up_idx] - CTR_BITS'(1);
        end
        ghr_d = (ghr_d << 1) | GHR_BITS'(upd_taken[i]);
        if (upd_mispredict[i]) pop = pop + 3'd1;
      end
    end
    misp_sum = {1'b0, misp_q} + 33'(pop);
    misp_d   = misp_sum[32] ? '1 : misp_sum[31:0];
  end

  // State registers with asynchronous reset; no update is taken while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < ENTRIES; e++) ctr_q[e] <= WEAK_NT;
      ghr_q  <= '0;
      misp_q <= '0;
    end else begin
      ctr_q  <= ctr_d;
      ghr_q  <= ghr_d;
      misp_q <= misp_d;
    end
  end

endmodule

// File: tb/tb_bpred_bht.sv
// Scoreboard bench for bpred_bht: a bimodal and a gshare instance share stimulus;
// a table-level model predicts outputs per cycle, a monitor compares on negedge.
module tb_bpred_bht;
  localparam int EN = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] lk_pc, upd_pc;
  logic [11:0] upd_ghr;
  logic [1:0]  upd_valid, upd_taken, upd_mispredict;
  logic [1:0]  p0, p1;
  logic [5:0]  g0, g1;
  logic [31:0] c0, c1;

  always #5 clk = ~clk;

  bpred_bht #(.ENTRIES(64), .CTR_BITS(2), .LANES(2), .GHR_BITS(6), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .predict_taken(p0), .ghr(g0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(c0));

  bpred_bht #(.ENTRIES(64), .CTR_BITS(2), .LANES(2), .GHR_BITS(6), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .predict_taken(p1), .ghr(g1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .mispredict_cnt(c1));

  typedef struct {
    logic [1:0]  p0;
    logic [1:0]  p1;
    logic [5:0]  g;
    logic [31:0] c;
  } exp_t;

  exp_t   q[$];
  int     ctr[2][EN];
  int     ghr_m;
  longint cnt_m;
  int     total = 0;
  int     bad   = 0;

  function automatic int mindex(input int m, input logic [31:0] pc, input int h);
    int b;
    b = int'((pc >> 2) % EN);
    return (m == 1) ? (b ^ h) : b;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int e = 0; e < EN; e++) ctr[m][e] = 1;
    ghr_m = 0;
    cnt_m = 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endfunction

  // Drive one cycle of inputs, record the expected outputs, then advance the model.
  task automatic apply(input bit r, input logic [1:0] v, input logic [1:0] tk,
                       input logic [1:0] mp, input logic [31:0] ua, input logic [31:0] ub,
                       input logic [5:0] ga, input logic [5:0] gb,
                       input logic [31:0] la, input logic [31:0] lb);
    exp_t        e;
    logic [31:0] upcs [2];
    int          ugs  [2];
    rst            = r;
    upd_valid      = v;
    upd_taken      = tk;
    upd_mispredict = mp;
    upd_pc         = {ub, ua};
    upd_ghr        = {gb, ga};
    lk_pc          = {lb, la};
    if (r) model_reset();
    e.p0[0] = (ctr[0][mindex(0, la, ghr_m)] >= 2);
    e.p0[1] = (ctr[0][mindex(0, lb, ghr_m)] >= 2);
    e.p1[0] = (ctr[1][mindex(1, la, ghr_m)] >= 2);
    e.p1[1] = (ctr[1][mindex(1, lb, ghr_m)] >= 2);
    e.g     = 6'(ghr_m);
    e.c     = 32'(cnt_m);
    q.push_back(e);
    if (!r) begin
      upcs[0] = ua; upcs[1] = ub;
      ugs[0]  = int'(ga); ugs[1] = int'(gb);
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          for (int m = 0; m < 2; m++) begin
            int ix;
            ix = mindex(m, upcs[l], ugs[l]);
            if (tk[l]) ctr[m][ix] = (ctr[m][ix] + 1 > 3) ? 3 : ctr[m][ix] + 1;
            else       ctr[m][ix] = (ctr[m][ix] - 1 < 0) ? 0 : ctr[m][ix] - 1;
          end
          ghr_m = ((ghr_m << 1) | int'(tk[l])) & 63;
          if (mp[l]) cnt_m = cnt_m + 1;
        end
      end
      if (cnt_m > 64'hFFFF_FFFF) cnt_m = 64'hFFFF_FFFF;
    end
  endtask

  task automatic step(input bit r, input logic [1:0] v, input logic [1:0] tk,
                      input logic [1:0] mp, input logic [31:0] ua, input logic [31:0] ub,
                      input logic [31:0] la, input logic [31:0] lb);
    @(posedge clk); #1;
    apply(r, v, tk, mp, ua, ub, 6'(ghr_m), 6'(ghr_m), la, lb);
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_bimodal", 32'(p0), 32'(e.p0));
      chk("pred_gshare",  32'(p1), 32'(e.p1));
      chk("ghr_bimodal",  32'(g0), 32'(e.g));
      chk("ghr_gshare",   32'(g1), 32'(e.g));
      chk("misp_cnt",     c0,      e.c);
      chk("misp_cnt_gs",  c1,      e.c);
    end
  end

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0020;

  initial begin
    rst = 1'b1; upd_valid = '0; upd_taken = '0; upd_mispredict = '0;
    upd_pc = '0; upd_ghr = '0; lk_pc = '0;
    model_reset();

    // reset state
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, PA, PA);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, PA, PA);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PA, PA);

    // single-lane training up, down, and floor
    step(0, 2'b01, 2'b01, 2'b00, PA, 0, PA, PA);
    step(0, 2'b01, 2'b01, 2'b00, PA, 0, PA, PA);
    for (int k = 0; k < 4; k++) step(0, 2'b01, 2'b00, 2'b00, PA, 0, PA, PA);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PA, PA);

    // dual same-index update with read-during-write
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, PB, PB);
    step(0, 2'b01, 2'b01, 2'b00, PB, 0, PB, PB);
    step(0, 2'b11, 2'b11, 2'b00, PB, PB, PB, PB);
    step(0, 2'b11, 2'b11, 2'b00, PB, PB, PB, PB);
    step(0, 2'b11, 2'b10, 2'b00, PB, PB, PB, PB);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PB, PB);

    // history: T, N, T on lane 0 then lookup pc 0 (gshare entry 5)
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 2'b01, 2'b00, 32'h0000_0014, 0, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 32'h0000_0000, 0, 0, 0);
    step(0, 2'b01, 2'b01, 2'b00, 32'h0000_0014, 0, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0014);

    // dual update ordering of history shift
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 2'b01, 2'b00, PA, PB, PA, PB);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PA, PB);

    // mispredict counting, ignored when not valid
    for (int k = 0; k < 5; k++) step(0, 2'b11, 2'b10, 2'b11, PA, PB, PA, PB);
    step(0, 2'b00, 2'b00, 2'b11, PA, PB, PA, PB);
    step(0, 2'b10, 2'b00, 2'b11, PA, PB, PA, PB);

    // saturation near the top of the counter
    @(posedge clk); #1;
    force dut0.misp_q = 32'hFFFF_FFFE;
    force dut1.misp_q = 32'hFFFF_FFFE;
    #1;
    release dut0.misp_q;
    release dut1.misp_q;
    cnt_m = 64'hFFFF_FFFE;
    apply(0, 2'b11, 2'b11, 2'b11, PA, PB, 6'(ghr_m), 6'(ghr_m), PA, PB);
    step(0, 2'b11, 2'b01, 2'b11, PA, PB, PA, PB);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PA, PB);

    // reset mid-burst drops the update on that edge
    step(0, 2'b11, 2'b11, 2'b11, PA, PA, PA, PA);
    step(1, 2'b11, 2'b11, 2'b11, PA, PA, PA, PA);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, PA, PA);

    // randomized traffic with heavy aliasing
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ua, ub, la, lb;
      logic [5:0]  ga, gb;
      bit          r;
      ua = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      ub = ($urandom_range(0, 2) == 0) ? ua
           : (($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2));
      la = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      lb = ($urandom_range(0, 1) == 0) ? ua : la;
      ga = ($urandom_range(0, 1) == 0) ? 6'(ghr_m) : 6'($urandom);
      gb = ($urandom_range(0, 1) == 0) ? 6'(ghr_m) : 6'($urandom);
      r  = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
      apply(r, 2'($urandom), 2'($urandom), 2'($urandom), ua, ub, ga, gb, la, lb);
    end

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
